dcc_adc_pattern_gen: RTL and testbench
======================================

Name: dcc_adc_pattern_gen

Overview:
Synthesizable, parametrised ADC stimulus source for the DCC data-conversion card. It replaces fixed ADC words and free-running DCO toggles with a run-time configurable generator: N channels, W-bit words, and constant/ramp/toggle/PRBS modes. It supports burst or continuous runs, a divided DCO-style strobe and an overrange flag. It sits in front of the ADC capture path, muxed against real ADA_D/ADB_D, for bring-up and in-system self-test.

Parameters:
CH, 2, number of channels (>=1)
W, 14, sample width per channel (2..15)
DIV, 2, system clocks per sample (>=2)
CNT_W, 16, width of burst length counter

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
START  in  1  1-cycle start request; latches all CFG_* inputs
STOP  in  1  abort request
CFG_MODE  in  2  0=CONST, 1=RAMP, 2=TOGGLE, 3=PRBS
CFG_BASE  in  CH*W  per-channel base/seed; channel k = bits [k*W +: W]
CFG_STEP  in  W  ramp increment, shared by all channels
BURST_LEN  in  CNT_W  samples per run; 0 = continuous
BUSY  out  1  high while in RUN
DONE  out  1  1-cycle pulse when a burst completes
DCO  out  1  sample clock image, high for the second half of each sample period
SAMPLE_VALID  out  1  1-cycle strobe per sample
SAMPLE_DATA  out  CH*W  channel words, valid with SAMPLE_VALID
OR  out  CH  per-channel overrange, qualified by SAMPLE_VALID

Behaviour:
- Reset: all outputs 0; FSM IDLE; div_cnt=0; sample_cnt=0.
- FSM states:
  - IDLE: START=1 and STOP=0 -> RUN. Mode, base, step and length are latched and generators preloaded.
  - RUN: STOP -> IDLE on the next edge, with no DONE and no further SAMPLE_VALID. Burst complete -> FIN.
  - FIN: DONE=1 for this cycle only, then -> IDLE.
- START during RUN/FIN is ignored. START and STOP together in IDLE: STOP wins, remain IDLE.
- BUSY=1 exactly in RUN.
- Divider:
  - div_cnt counts 0..DIV-1 in RUN and is held at 0 otherwise.
  - SAMPLE_VALID=1 when div_cnt==DIV-1, so the first strobe comes DIV cycles after the START edge.
  - DCO=1 when div_cnt>=DIV/2 (integer division) in RUN, else 0.
- Sample n (n=0,1,...) per channel k, where b = base slice:
  - CONST: b.
  - RAMP: (b + n*STEP) mod 2^W.
  - TOGGLE: b for even n, ~b for odd n.
  - PRBS: 15-bit Fibonacci LFSR x^15+x^14+1, one shift per sample. Seed {zero-pad, b}; an all-zero seed is replaced with 15'h0001. Output = low W bits of the state before the shift, so sample 0 shows the seed.
- OR[k]:
  - RAMP: 1 on a sample whose value wrapped, i.e. the add from the previous sample carried out of bit W-1. Never set on sample 0.
  - CONST/TOGGLE: 1 when the output word is all ones.
  - PRBS: 0.
- Burst: sample_cnt increments on each SAMPLE_VALID. When a nonzero BURST_LEN is reached, the next state is FIN.
  - Exactly BURST_LEN strobes are issued.
  - Continuous mode runs until STOP; sample_cnt wraps silently.
- SAMPLE_DATA holds the last sample between strobes and in IDLE. OR is 0 whenever SAMPLE_VALID=0.
- Reset mid-run: immediate return to IDLE with all outputs 0 on the next edge; no DONE.
- All sample arithmetic is unsigned modulo 2^W. STEP=0 in RAMP degenerates to CONST with OR=0.

Decomposition:
- Package dcc_pkg:
  - mode enum (MODE_CONST, MODE_RAMP, MODE_TOGGLE, MODE_PRBS)
  - FSM state enum (S_IDLE, S_RUN, S_FIN)
  - LFSR width constant (15) and tap positions
  - default seed constant
- Sub-module dcc_chan_gen: one channel (mode mux, ramp adder with carry, LFSR, OR logic), instantiated CH times in a generate loop.
- Top level keeps the FSM, divider and burst counter.

Test Plan:
- RST held 3 cycles mid-RUN -> all outputs 0 the next cycle, BUSY=0, no DONE; a subsequent START works normally.
- CONST, CH=2, W=14, DIV=2, base {1215,215}, BURST_LEN=4 -> strobes at cycles 2,4,6,8 after START with ch0=215, ch1=1215; DONE one cycle after the 4th strobe; BUSY low thereafter.
- RAMP, base ch0=16380, STEP=3, BURST_LEN=3 -> samples 16380, 16383, 2; OR[0] only on the third sample.
- TOGGLE, base 0x0000, BURST_LEN=2 -> samples 0x0000 then 0x3FFF with OR=1 on the second.
- PRBS, seed 0, W=14, BURST_LEN=0 -> first sample 0x0001, sequence matches the x^15+x^14+1 reference model for 100 samples; STOP -> BUSY falls next edge, no DONE, no further strobes.
- START+STOP in the same IDLE cycle -> stays IDLE. START during RUN -> ignored, burst length unchanged. DIV=5 -> DCO high for 3 of 5 cycles, strobe every 5 cycles.

Source files
------------

// File: rtl/dcc_pkg.sv
// Shared types and constants for the DCC ADC pattern generator.
package dcc_pkg;

   // Pattern modes selectable through CFG_MODE
   typedef enum logic [1:0] {
      MODE_CONST  = 2'd0,
      MODE_RAMP   = 2'd1,
      MODE_TOGGLE = 2'd2,
      MODE_PRBS   = 2'd3
   } mode_e;

   // Run-control states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   // PRBS generator: Fibonacci LFSR for x^15 + x^14 + 1
   localparam int LFSR_W      = 15;
   localparam int LFSR_TAP_HI = 14;
   localparam int LFSR_TAP_LO = 13;

   // Replacement for an all-zero seed, which would lock the LFSR
   localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 15'h0001;

   // One LFSR shift: feedback enters at bit 0
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
   endfunction

endpackage

// File: rtl/dcc_chan_gen.sv
// One pattern channel: constant, ramp with wrap detect, toggle and PRBS.
// The current sample is always presented on data/ovr; adv moves to the next one.
module dcc_chan_gen
   import dcc_pkg::*;
#(
   parameter int W = 14
)
(
   input  logic         clk,
   input  logic         srst,
   input  logic         load,
   input  logic         adv,
   input  mode_e        mode,
   input  logic [W-1:0] base,
   input  logic [W-1:0] step,
   output logic [W-1:0] data,
   output logic         ovr
);

   logic [W-1:0]      base_reg;
   logic [W-1:0]      acc_reg;
   logic              wrap_reg;
   logic              phase_reg;
   logic [LFSR_W-1:0] lfsr_reg;
   logic [LFSR_W-1:0] seed_next;
   logic [W:0]        ramp_sum;
   logic [W-1:0]      tog_word;

   // Extra top bit of the ramp adder is the wrap (carry out of bit W-1)
   assign ramp_sum = {1'b0, acc_reg} + {1'b0, step};
   assign tog_word = phase_reg ? ~base_reg : base_reg;

   // Zero-extend the base into an LFSR seed, substituting a nonzero default
   always_comb begin
      seed_next = LFSR_W'(base);
      if (seed_next == '0) seed_next = LFSR_SEED_DEFAULT;
   end

   // Generator state: preload on run start, step once per issued sample
   always_ff @(posedge clk) begin
      if (srst) begin
         base_reg  <= '0;
         acc_reg   <= '0;
         wrap_reg  <= 1'b0;
         phase_reg <= 1'b0;
         lfsr_reg  <= '0;
      end else if (load) begin
         base_reg  <= base;
         acc_reg   <= base;
         wrap_reg  <= 1'b0;
         phase_reg <= 1'b0;
         lfsr_reg  <= seed_next;
      end else if (adv) begin
         acc_reg   <= ramp_sum[W-1:0];
         wrap_reg  <= ramp_sum[W];
         phase_reg <= ~phase_reg;
         lfsr_reg  <= lfsr_step(lfsr_reg);
      end
   end

   // Mode mux for the current sample word and its overrange flag
   always_comb begin
      data = base_reg;
      ovr  = 1'b0;
      case (mode)
         MODE_CONST: begin
            data = base_reg;
            ovr  = &base_reg;
         end
         MODE_RAMP: begin
            data = acc_reg;
            ovr  = wrap_reg;
         end
         MODE_TOGGLE: begin
            data = tog_word;
            ovr  = &tog_word;
         end
         default: begin
            data = lfsr_reg[W-1:0];
            ovr  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dcc_adc_pattern_gen.sv
// ADC stimulus source: run control FSM, sample-rate divider, burst counter
// and CH pattern channels. Strobe/DCO are decoded from the divider count.
module dcc_adc_pattern_gen
   import dcc_pkg::*;
#(
   parameter int CH    = 2,
   parameter int W     = 14,
   parameter int DIV   = 2,
   parameter int CNT_W = 16
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              STOP,
   input  logic [1:0]        CFG_MODE,
   input  logic [CH*W-1:0]   CFG_BASE,
   input  logic [W-1:0]      CFG_STEP,
   input  logic [CNT_W-1:0]  BURST_LEN,
   output logic              BUSY,
   output logic              DONE,
   output logic              DCO,
   output logic              SAMPLE_VALID,
   output logic [CH*W-1:0]   SAMPLE_DATA,
   output logic [CH-1:0]     OR
);

   localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] DCO_ON   = DIV_W'(DIV / 2);

   state_e            state_reg;
   state_e            state_next;
   logic [DIV_W-1:0]  div_cnt_reg;
   logic [CNT_W-1:0]  sample_cnt_reg;
   logic [CNT_W-1:0]  len_reg;
   mode_e             mode_reg;
   logic [W-1:0]      step_reg;
   logic [CH*W-1:0]   hold_reg;
   logic [CH*W-1:0]   gen_data;
   logic [CH-1:0]     gen_or;
   logic              in_run;
   logic              strobe;
   logic              burst_last;
   logic              start_accept;

   assign in_run       = (state_reg == S_RUN);
   assign strobe       = in_run && (div_cnt_reg == DIV_LAST);
   assign burst_last   = (len_reg != '0) && ((sample_cnt_reg + CNT_W'(1)) == len_reg);
   assign start_accept = (state_reg == S_IDLE) && START && !STOP;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // Next state and decoded outputs; STOP overrides burst completion
   always_comb begin
      state_next   = state_reg;
      BUSY         = in_run;
      DONE         = (state_reg == S_FIN);
      DCO          = in_run && (div_cnt_reg >= DCO_ON);
      SAMPLE_VALID = strobe;
      SAMPLE_DATA  = strobe ? gen_data : hold_reg;
      OR           = strobe ? gen_or : '0;
      case (state_reg)
         S_IDLE: if (start_accept) state_next = S_RUN;
         S_RUN: begin
            if (STOP)                      state_next = S_IDLE;
            else if (strobe && burst_last) state_next = S_FIN;
         end
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Sample-rate divider: free-runs only while staying in RUN
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt_reg <= '0;
      end else if (in_run && (state_next == S_RUN)) begin
         div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
      end else begin
         div_cnt_reg <= '0;
      end
   end

   // Burst counter and run configuration captured on an accepted START
   always_ff @(posedge CLK) begin
      if (RST) begin
         sample_cnt_reg <= '0;
         len_reg        <= '0;
         mode_reg       <= MODE_CONST;
         step_reg       <= '0;
      end else if (start_accept) begin
         sample_cnt_reg <= '0;
         len_reg        <= BURST_LEN;
         mode_reg       <= mode_e'(CFG_MODE);
         step_reg       <= CFG_STEP;
      end else if (strobe) begin
         sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
      end
   end

   // Last issued sample, shown on SAMPLE_DATA between strobes
   always_ff @(posedge CLK) begin
      if (RST)         hold_reg <= '0;
      else if (strobe) hold_reg <= gen_data;
   end

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_chan
         dcc_chan_gen #(
            .W (W)
         ) u_chan (
            .clk  (CLK),
            .srst (RST),
            .load (start_accept),
            .adv  (strobe),
            .mode (mode_reg),
            .base (CFG_BASE[gi*W +: W]),
            .step (step_reg),
            .data (gen_data[gi*W +: W]),
            .ovr  (gen_or[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_dcc_adc_pattern_gen.sv
// Self-checking bench for dcc_adc_pattern_gen: vector table of bursts checked
// through a sample scoreboard, plus hand sequences for timing and control cases.
module tb_dcc_adc_pattern_gen;

   localparam int CH = 2;
   localparam int W  = 14;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              stop;
   logic [1:0]        cfg_mode;
   logic [CH*W-1:0]   cfg_base;
   logic [W-1:0]      cfg_step;
   logic [15:0]       burst_len;

   logic              busy, done, dco, sample_valid;
   logic [CH*W-1:0]   sample_data;
   logic [CH-1:0]     ovr;
   logic              busy5, done5, dco5, valid5;
   logic [CH*W-1:0]   data5;
   logic [CH-1:0]     ovr5;

   always #5 clk = ~clk;

   dcc_adc_pattern_gen #(.CH(CH), .W(W), .DIV(2), .CNT_W(16)) dut (
      .CLK(clk), .RST(rst), .START(start), .STOP(stop),
      .CFG_MODE(cfg_mode), .CFG_BASE(cfg_base), .CFG_STEP(cfg_step), .BURST_LEN(burst_len),
      .BUSY(busy), .DONE(done), .DCO(dco), .SAMPLE_VALID(sample_valid),
      .SAMPLE_DATA(sample_data), .OR(ovr)
   );

   dcc_adc_pattern_gen #(.CH(CH), .W(W), .DIV(5), .CNT_W(16)) dut5 (
      .CLK(clk), .RST(rst), .START(start), .STOP(stop),
      .CFG_MODE(cfg_mode), .CFG_BASE(cfg_base), .CFG_STEP(cfg_step), .BURST_LEN(burst_len),
      .BUSY(busy5), .DONE(done5), .DCO(dco5), .SAMPLE_VALID(valid5),
      .SAMPLE_DATA(data5), .OR(ovr5)
   );

   typedef struct {
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      logic [1:0]   o;
   } exp_t;

   typedef struct {
      int           mode;
      logic [W-1:0] b0;
      logic [W-1:0] b1;
      logic [W-1:0] step;
      logic [15:0]  len;
      logic [W-1:0] first0;
      logic [W-1:0] last0;
      logic         or_last0;
   } vec_t;

   exp_t         sb_q[$];
   exp_t         mon_e;
   vec_t         vecs[7];
   int           checks = 0;
   int           errors = 0;
   int           strobe_cnt = 0;
   int           done_cnt = 0;
   int           run_strobes = 0;
   logic [W-1:0] first0, last0;
   logic         last_or0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference sample n of one channel, written from the pattern definitions
   function automatic void model(input int mode, input logic [W-1:0] b, input logic [W-1:0] step,
                                 input int n, output logic [W-1:0] d, output logic o);
      longint v, vp;
      logic [14:0] s;
      d = b;
      o = 1'b0;
      case (mode)
         0: begin
            d = b;
            o = (b == 14'h3FFF);
         end
         1: begin
            v = longint'(b) + longint'(n) * longint'(step);
            d = 14'(v % 16384);
            if (n > 0) begin
               vp = v - longint'(step);
               o  = ((v / 16384) != (vp / 16384));
            end
         end
         2: begin
            d = (n % 2 == 1) ? ~b : b;
            o = (d == 14'h3FFF);
         end
         default: begin
            s = (b == '0) ? 15'd1 : {1'b0, b};
            for (int i = 0; i < n; i++) s = {s[13:0], s[14] ^ s[13]};
            d = s[13:0];
            o = 1'b0;
         end
      endcase
   endfunction

   task automatic push_expected(input int mode, input logic [W-1:0] b0, input logic [W-1:0] b1,
                                input logic [W-1:0] step, input int count);
      exp_t e;
      logic o0, o1;
      for (int n = 0; n < count; n++) begin
         model(mode, b0, step, n, e.d0, o0);
         model(mode, b1, step, n, e.d1, o1);
         e.o = {o1, o0};
         sb_q.push_back(e);
      end
   endtask

   // Scoreboard: every strobe of the DIV=2 instance pops one expected sample
   always @(negedge clk) begin
      if (sample_valid) begin
         strobe_cnt++;
         if (sb_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("data_ch0", sample_data[W-1:0], mon_e.d0);
            check("data_ch1", sample_data[2*W-1:W], mon_e.d1);
            check("or_flags", ovr, mon_e.o);
         end
         if (run_strobes == 0) first0 = sample_data[W-1:0];
         last0    = sample_data[W-1:0];
         last_or0 = ovr[0];
         run_strobes++;
      end else if (ovr != '0) begin
         check("or_unqualified", ovr, 32'd0);
      end
      if (done) done_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int mode, input logic [W-1:0] b0, input logic [W-1:0] b1,
                            input logic [W-1:0] step, input logic [15:0] len);
      cfg_mode  = 2'(mode);
      cfg_base  = {b1, b0};
      cfg_step  = step;
      burst_len = len;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic run_vector(input vec_t v);
      int d0;
      push_expected(v.mode, v.b0, v.b1, v.step, int'(v.len));
      run_strobes = 0;
      d0 = done_cnt;
      start_run(v.mode, v.b0, v.b1, v.step, v.len);
      for (int c = 0; c < 200 && done_cnt == d0; c++) tick();
      check("done_count", done_cnt - d0, 32'd1);
      check("strobe_count", run_strobes, v.len);
      check("first_ch0", first0, v.first0);
      check("last_ch0", last0, v.last0);
      check("or_last_ch0", last_or0, v.or_last0);
      check("busy_after_done", busy, 32'd0);
      check("hold_data_ch0", sample_data[W-1:0], v.last0);
      sb_q.delete();
   endtask

   initial begin
      int s0, d0;
      bit reached;

      //          mode  b0        b1        step      len  first0    last0     or_last0
      vecs[0] = '{0, 14'd215,   14'd1215, 14'd0,    16'd4, 14'd215,   14'd215,   1'b0};
      vecs[1] = '{1, 14'd16380, 14'd100,  14'd3,    16'd3, 14'd16380, 14'd2,     1'b1};
      vecs[2] = '{2, 14'h0000,  14'h1555, 14'd0,    16'd2, 14'h0000,  14'h3FFF,  1'b1};
      vecs[3] = '{0, 14'h3FFF,  14'd5,    14'd0,    16'd2, 14'h3FFF,  14'h3FFF,  1'b1};
      vecs[4] = '{1, 14'h3FFF,  14'd7,    14'd0,    16'd3, 14'h3FFF,  14'h3FFF,  1'b0};
      vecs[5] = '{3, 14'h1234,  14'h0000, 14'd0,    16'd5, 14'h1234,  14'h2346,  1'b0};
      vecs[6] = '{1, 14'h2001,  14'h3FFE, 14'h2000, 16'd4, 14'h2001,  14'h0001,  1'b1};

      rst = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_mode = '0; cfg_base = '0; cfg_step = '0; burst_len = '0;
      repeat (3) tick();
      check("rst_busy", busy, 32'd0);
      check("rst_done", done, 32'd0);
      check("rst_dco", dco, 32'd0);
      check("rst_valid", sample_valid, 32'd0);
      check("rst_data", sample_data, 32'd0);
      check("rst_or", ovr, 32'd0);
      rst = 1'b0;
      tick();

      // CONST burst timing: strobes on cycles 2,4,6,8 after START, DONE on 9
      push_expected(0, 14'd215, 14'd1215, 14'd0, 4);
      run_strobes = 0;
      start_run(0, 14'd215, 14'd1215, 14'd0, 16'd4);
      for (int c = 1; c <= 10; c++) begin
         check($sformatf("t_valid_c%0d", c), sample_valid, (c % 2 == 0) && (c <= 8));
         check($sformatf("t_done_c%0d", c), done, (c == 9));
         check($sformatf("t_busy_c%0d", c), busy, (c <= 8));
         check($sformatf("t_dco_c%0d", c), dco, (c <= 8) && (c % 2 == 0));
         tick();
      end
      sb_q.delete();

      for (int i = 0; i < 7; i++) run_vector(vecs[i]);

      // START and STOP together in IDLE: no run
      s0 = strobe_cnt;
      cfg_mode = 2'd0; cfg_base = '0; burst_len = 16'd2;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check("startstop_busy", busy, 32'd0);
         tick();
      end
      check("startstop_strobes", strobe_cnt - s0, 32'd0);

      // START during RUN is ignored: original config and length stand
      push_expected(0, 14'h0AAA, 14'h0555, 14'd0, 3);
      s0 = strobe_cnt; d0 = done_cnt;
      start_run(0, 14'h0AAA, 14'h0555, 14'd0, 16'd3);
      tick();
      cfg_base = {14'h1111, 14'h1111}; burst_len = 16'd10;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 50 && done_cnt == d0; c++) tick();
      repeat (5) tick();
      check("ignored_start_strobes", strobe_cnt - s0, 32'd3);
      check("ignored_start_done", done_cnt - d0, 32'd1);
      check("ignored_start_busy", busy, 32'd0);
      sb_q.delete();

      // Continuous PRBS from a zero seed, stopped after 100 samples
      push_expected(3, 14'd0, 14'd0, 14'd0, 100);
      s0 = strobe_cnt; d0 = done_cnt;
      start_run(3, 14'd0, 14'd0, 14'd0, 16'd0);
      reached = 1'b0;
      for (int c = 0; c < 1000 && !reached; c++) begin
         @(negedge clk);
         #1;
         if (strobe_cnt - s0 >= 100) reached = 1'b1;
      end
      check("prbs_reached_100", reached, 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_busy", busy, 32'd0);
      check("stop_sb_empty", sb_q.size(), 32'd0);
      repeat (10) tick();
      check("stop_strobes", strobe_cnt - s0, 32'd100);
      check("stop_no_done", done_cnt - d0, 32'd0);
      sb_q.delete();

      // Reset held 3 cycles mid-run
      push_expected(0, 14'h0123, 14'h0321, 14'd0, 10);
      d0 = done_cnt;
      start_run(0, 14'h0123, 14'h0321, 14'd0, 16'd10);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("midrst_busy", busy, 32'd0);
      check("midrst_valid", sample_valid, 32'd0);
      check("midrst_done", done, 32'd0);
      check("midrst_dco", dco, 32'd0);
      check("midrst_data", sample_data, 32'd0);
      check("midrst_or", ovr, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      sb_q.delete();
      repeat (3) tick();
      check("midrst_no_done", done_cnt - d0, 32'd0);
      run_vector(vecs[1]);

      // DIV=5 instance: DCO high 3 of 5 cycles, strobe every 5th cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      push_expected(0, 14'h0042, 14'h0000, 14'd0, 2);
      start_run(0, 14'h0042, 14'h0000, 14'd0, 16'd2);
      for (int c = 1; c <= 11; c++) begin
         check($sformatf("d5_dco_c%0d", c), dco5, (c <= 10) && (((c - 1) % 5) >= 2));
         check($sformatf("d5_valid_c%0d", c), valid5, (c <= 10) && (((c - 1) % 5) == 4));
         check($sformatf("d5_done_c%0d", c), done5, (c == 11));
         if (c == 5 || c == 10) check("d5_data_ch0", data5[W-1:0], 14'h0042);
         tick();
      end
      sb_q.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
